// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, inverse S-box, FSM state type and round-count helper
package aes_pkg;

  localparam int AES_BLK = 128;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  // Byte 0x00 maps from the top byte; index with (255 - b).
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{8'hff - b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round; i_final skips InvMixColumns
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [AES_BLK-1:0] i_state,
  input  logic [AES_BLK-1:0] i_key,
  input  logic               i_final,
  output logic [AES_BLK-1:0] o_state
);

  // Byte i of the block lives in [127-8i -: 8]; byte i is row i%4, column i/4.
  function automatic logic [AES_BLK-1:0] inv_shift_rows(input logic [AES_BLK-1:0] s);
    logic [AES_BLK-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [AES_BLK-1:0] inv_sub_bytes(input logic [AES_BLK-1:0] s);
    logic [AES_BLK-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  function automatic logic [AES_BLK-1:0] inverse_mix_columns(input logic [AES_BLK-1:0] s);
    logic [AES_BLK-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9);
      o[119-32*c -: 8] = gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13);
      o[111-32*c -: 8] = gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11);
      o[103-32*c -: 8] = gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14);
    end
    return o;
  endfunction

  function automatic logic [AES_BLK-1:0] add_round_key(input logic [AES_BLK-1:0] s,
                                                       input logic [AES_BLK-1:0] k);
    return s ^ k;
  endfunction

  logic [AES_BLK-1:0] w_ark;

  assign w_ark   = add_round_key(inv_sub_bytes(inv_shift_rows(i_state)), i_key);
  assign o_state = i_final ? w_ark : inverse_mix_columns(w_ark);

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES-128/192/256 inverse cipher, one round per clock
// Optional abort port and abort paths enabled by defining AES_INV_ABORT_EN.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter  int NK  = 4,
  localparam int NR  = nr_of(NK),
  localparam int RKW = 128 * (NR + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AES_BLK-1:0] in_data,
  input  logic [RKW-1:0]     rk,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AES_BLK-1:0] out_data,
`ifdef AES_INV_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy
);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_inv_cipher_iter: NK must be 4, 6 or 8");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  state_e             r_fsm, w_fsm_nxt;
  logic [3:0]         r_rnd;
  logic [AES_BLK-1:0] r_blk, r_out_data;
  logic               r_out_valid, r_init;
  logic [AES_BLK-1:0] w_slots [NR+1];
  logic [3:0]         w_idx;
  logic [AES_BLK-1:0] w_key, w_round;
  logic               w_final, w_accept, w_kill;

  for (genvar k = 0; k <= NR; k++) begin : g_slot
    assign w_slots[k] = rk[128*k +: 128];
  end

  // rnd is 0 in IDLE, so the same mux hands slot 0 to the accept XOR.
  assign w_idx    = (r_rnd > NR_L) ? 4'd0 : r_rnd;
  assign w_key    = w_slots[w_idx];
  assign w_final  = (r_rnd == NR_L);
  assign w_accept = (r_fsm == IDLE) && r_init && in_valid;

`ifdef AES_INV_ABORT_EN
  assign w_kill = abort && (r_fsm != IDLE);
`else
  assign w_kill = 1'b0;
`endif

  aes_inv_round u_round (
    .i_state (r_blk),
    .i_key   (w_key),
    .i_final (w_final),
    .o_state (w_round)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      IDLE:    if (w_accept) w_fsm_nxt = ROUND;
      ROUND:   if (r_rnd > NR_L) w_fsm_nxt = IDLE;
               else if (r_rnd == NR_L) w_fsm_nxt = DONE;
      DONE:    if (out_ready) w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
    if (w_kill) w_fsm_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init      <= 1'b0;
      r_rnd       <= '0;
      r_blk       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_init <= 1'b1;
      case (r_fsm)
        IDLE: if (w_accept) begin
          r_blk <= in_data ^ w_key;
          r_rnd <= 4'd1;
        end
        ROUND: if (r_rnd > NR_L) begin
          r_rnd <= '0;
        end else if (w_final) begin
          r_out_data  <= w_round;
          r_out_valid <= 1'b1;
          r_rnd       <= '0;
        end else begin
          r_blk <= w_round;
          r_rnd <= r_rnd + 4'd1;
        end
        DONE: if (out_ready) r_out_valid <= 1'b0;
        default: r_rnd <= '0;
      endcase
      if (w_kill) begin
        r_out_valid <= 1'b0;
        r_rnd       <= '0;
      end
    end
  end

  assign in_ready  = (r_fsm == IDLE) && r_init;
  assign busy      = (r_fsm == ROUND);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb/tb_aes_inv_cipher_iter.sv - bench for aes_inv_cipher_iter at NK=4/6/8 with a forward-cipher model
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid [3];
  logic         in_ready [3];
  logic         out_valid[3];
  logic         out_ready[3];
  logic         busy     [3];
  logic [127:0] in_data  [3];
  logic [127:0] out_data [3];
  logic [1919:0] rk      [3];
`ifdef AES_INV_ABORT_EN
  logic         abort    [3];
`endif

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int NKK = (k == 0) ? 4 : (k == 1) ? 6 : 8;
    aes_inv_cipher_iter #(.NK(NKK)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_data   (in_data[k]),
      .rk        (rk[k][128*(NKK+7)-1:0]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k]),
`ifdef AES_INV_ABORT_EN
      .abort     (abort[k]),
`endif
      .busy      (busy[k])
    );
  end

  typedef struct {
    int           d;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  logic [7:0]   sb [256];
  logic [127:0] rkeys [3][15];
  logic [127:0] exp_q [$];
  logic [127:0] cur_pt;
  int n_checks = 0, n_fail = 0, cyc = 0, acc_edge = 0;

  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;

  function automatic int nr_d(input int d);
    return 10 + 2 * d;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input int d, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nr = nr_d(d);
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    rk[d] = '0;
    for (int r = 0; r <= nr; r++) rkeys[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int k = 0; k <= nr; k++) rk[d][128*k +: 128] = rkeys[d][nr-k];
  endtask

  function automatic logic [127:0] encrypt(input int d, input logic [127:0] pt);
    logic [127:0] s, o;
    logic [7:0] a0, a1, a2, a3;
    s = pt ^ rkeys[d][0];
    for (int r = 1; r <= nr_d(d); r++) begin
      for (int i = 0; i < 16; i++) s[8*i +: 8] = sb[s[8*i +: 8]];
      o = '0;
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          o[127-8*(4*c+q) -: 8] = s[127-8*(4*((c+q)%4)+q) -: 8];
      s = o;
      if (r < nr_d(d)) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        s = o;
      end
      s = s ^ rkeys[d][r];
    end
    return s;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Push on accept, pop and compare on output handshake, then advance one edge.
  task automatic step(input int d);
    logic acc, hs;
    acc = in_valid[d] && in_ready[d];
    hs  = out_valid[d] && out_ready[d];
    if (acc) begin
      exp_q.push_back(cur_pt);
      acc_edge = cyc + 1;
    end
    if (hs) begin
      if (exp_q.size() == 0) chk("unexpected_output", out_data[d], 128'hx);
      else chk("out_data", out_data[d], exp_q.pop_front());
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_block(input int d, input logic [127:0] ct, input logic [127:0] pt,
                           input int hold);
    int n;
    logic [127:0] held;
    in_data[d] = ct; in_valid[d] = 1'b1; cur_pt = pt;
    step(d);
    in_valid[d] = 1'b0; in_data[d] = ~ct;
    chk("busy_after_accept", 128'(busy[d]), 128'd1);
    n = 0;
    while (!out_valid[d] && n < 40) begin step(d); n++; end
    chk("latency", 128'(cyc - acc_edge), 128'(nr_d(d)));
    if (hold > 0) begin
      out_ready[d] = 1'b0;
      held = out_data[d];
      for (int i = 0; i < hold; i++) begin
        step(d);
        chk("hold_data", out_data[d], held);
        chk("hold_v_rdy_busy", 128'({out_valid[d], in_ready[d], busy[d]}), 128'b100);
      end
      out_ready[d] = 1'b1;
    end
    step(d);
    chk("idle_after_xfer", 128'({out_valid[d], in_ready[d]}), 128'b01);
  endtask

  vec_t vt[9];
  int   t_ev[2];
  int   ev, n;
  logic seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b1; in_data[i] = '0; rk[i] = '0;
`ifdef AES_INV_ABORT_EN
      abort[i] = 1'b0;
`endif
    end
    init_sbox();

    vt[0] = '{d: 0, key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
              ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, pt: PT_FIPS};
    vt[1] = '{d: 1, key: {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
              ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191, pt: PT_FIPS};
    vt[2] = '{d: 2, key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              ct: 128'h8ea2b7ca516745bfeafc49904b496089, pt: PT_FIPS};
    for (int i = 3; i < 9; i++) begin
      vt[i].d   = (i - 3) % 3;
      vt[i].key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      vt[i].pt  = {$urandom, $urandom, $urandom, $urandom};
      expand(vt[i].d, vt[i].key);
      vt[i].ct  = encrypt(vt[i].d, vt[i].pt);
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk("reset_state", 128'({in_ready[i], out_valid[i], busy[i]}) | (out_data[i] << 3), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) chk("in_ready_after_reset", 128'(in_ready[i]), 128'd1);

    for (int i = 0; i < 9; i++) begin
      expand(vt[i].d, vt[i].key);
      run_block(vt[i].d, vt[i].ct, vt[i].pt, 0);
    end

    // back-pressure on the AES-128 instance
    expand(0, vt[0].key);
    run_block(0, vt[0].ct, PT_FIPS, 5);

    // back-to-back blocks with in_valid held high
    expand(2, vt[2].key);
    in_data[2] = vt[2].ct; in_valid[2] = 1'b1; cur_pt = PT_FIPS;
    ev = 0; n = 0; t_ev[0] = 0; t_ev[1] = 0;
    while (ev < 2 && n < 80) begin
      step(2); n++;
      if (out_valid[2]) begin t_ev[ev] = cyc; ev++; end
    end
    in_valid[2] = 1'b0;
    step(2);
    chk("throughput", 128'(t_ev[1] - t_ev[0]), 128'(nr_d(2) + 2));

    // async reset in the middle of a block
    expand(0, vt[0].key);
    in_data[0] = vt[0].ct; in_valid[0] = 1'b1; cur_pt = PT_FIPS;
    step(0);
    in_valid[0] = 1'b0;
    repeat (5) step(0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_clear", 128'({out_valid[0], busy[0], in_ready[0]}) | (out_data[0] << 3), 128'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (nr_d(0) + 3) begin step(0); seen = seen | out_valid[0]; end
    chk("no_output_after_reset", 128'(seen), 128'd0);
    run_block(0, vt[0].ct, PT_FIPS, 0);

`ifdef AES_INV_ABORT_EN
    in_data[0] = vt[0].ct; in_valid[0] = 1'b1; cur_pt = PT_FIPS;
    step(0);
    in_valid[0] = 1'b0;
    repeat (2) step(0);
    abort[0] = 1'b1;
    step(0);
    abort[0] = 1'b0;
    chk("abort_to_idle", 128'({out_valid[0], busy[0], in_ready[0]}), 128'b001);
    void'(exp_q.pop_back());
    seen = 1'b0;
    repeat (nr_d(0) + 2) begin step(0); seen = seen | out_valid[0]; end
    chk("no_output_after_abort", 128'(seen), 128'd0);
    run_block(0, vt[0].ct, PT_FIPS, 0);
`endif

    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
